// File: rtl/smart_mac_pkg.sv
// Shared encodings for the multi-region SMART memory access controller.
//   cfg_sel_e    : configuration field select (safe/code low/high bounds)
//   viol_cause_e : cause reported for the last violation
//   state_e      : controller state (config, monitor, resetting)
//   code_t       : current-code-region tag, CodeNone when outside every region
package smart_mac_pkg;

  typedef enum logic [1:0] {
    SelSafeLo = 2'd0,
    SelSafeHi = 2'd1,
    SelCodeLo = 2'd2,
    SelCodeHi = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    CauseNone  = 2'b00,
    CauseData  = 2'b01,
    CauseEntry = 2'b10
  } viol_cause_e;

  typedef enum logic [1:0] {
    StConfig    = 2'd0,
    StMonitor   = 2'd1,
    StResetting = 2'd2
  } state_e;

  localparam int unsigned MaxRegions = 8;
  localparam int unsigned CodeW      = 4;

  typedef logic [CodeW-1:0] code_t;

  // One past the largest region index, so it never aliases a real region.
  localparam code_t CodeNone = code_t'(MaxRegions);

endpackage

// File: rtl/smart_region_check.sv
// One key/code region pair: holds the four bound registers and range-matches
// the current data and fetch addresses against them.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   wr_en_i        : write the field chosen by wr_sel_i with wr_data_i
//   mem_addr_i     : data access address
//   ins_addr_i     : fetch address
//   active_o       : both ranges are non-empty
//   safe_hit_o     : mem_addr_i in [safe_lo, safe_hi) (not gated by active_o)
//   code_hit_o     : ins_addr_i in [code_lo, code_hi) (not gated by active_o)
//   is_entry_o     : ins_addr_i equals the region entry point (code_lo)
module smart_region_check
  import smart_mac_pkg::*;
#(
  parameter int unsigned AddrW = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [AddrW-1:0] wr_data_i,
  input  logic [AddrW-1:0] mem_addr_i,
  input  logic [AddrW-1:0] ins_addr_i,
  output logic             active_o,
  output logic             safe_hit_o,
  output logic             code_hit_o,
  output logic             is_entry_o
);

  logic [AddrW-1:0] safe_lo_q, safe_hi_q, code_lo_q, code_hi_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      safe_lo_q <= '0;
      safe_hi_q <= '0;
      code_lo_q <= '0;
      code_hi_q <= '0;
    end else if (wr_en_i) begin
      unique case (cfg_sel_e'(wr_sel_i))
        SelSafeLo: safe_lo_q <= wr_data_i;
        SelSafeHi: safe_hi_q <= wr_data_i;
        SelCodeLo: code_lo_q <= wr_data_i;
        SelCodeHi: code_hi_q <= wr_data_i;
      endcase
    end
  end

  always_comb begin
    active_o   = (safe_lo_q < safe_hi_q) && (code_lo_q < code_hi_q);
    safe_hit_o = (mem_addr_i >= safe_lo_q) && (mem_addr_i < safe_hi_q);
    code_hit_o = (ins_addr_i >= code_lo_q) && (ins_addr_i < code_hi_q);
    is_entry_o = (ins_addr_i == code_lo_q);
  end

endmodule

// File: rtl/smart_mac_multi.sv
// Multi-region SMART memory access controller. Guards NUM_REGIONS key regions,
// each reachable only from its own trusted code region, which in turn may only
// be entered at its first address. A breach raises a RST_CYCLES-long CPU reset.
//   mclk, reset_n           : clock, synchronous active-low reset
//   cfg_we/idx/sel/data     : write-once region table programming
//   cfg_lock                : freeze the table and start monitoring
//   mem_en, mem_addr        : data bus access
//   ins_valid, ins_addr     : instruction fetch
//   dbg_en_req              : debug enable request
//   locked                  : table frozen
//   violation_rst           : reset request to the CPU
//   viol_region, viol_cause : region and cause of the last violation
//   in_safe_area            : CPU executing inside a trusted code region
//   dbg_en                  : gated debug enable
module smart_mac_multi
  import smart_mac_pkg::*;
#(
  parameter  int unsigned NUM_REGIONS = 4,
  parameter  int unsigned ADDR_W      = 16,
  parameter  int unsigned RST_CYCLES  = 4,
  localparam int unsigned IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_lock,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              ins_valid,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic              dbg_en_req,
  output logic              locked,
  output logic              violation_rst,
  output logic [IDX_W-1:0]  viol_region,
  output logic [1:0]        viol_cause,
  output logic              in_safe_area,
  output logic              dbg_en
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e           state_q;
  logic             locked_q, viol_rst_q, in_safe_q;
  logic [IDX_W-1:0] viol_region_q;
  viol_cause_e      viol_cause_q;
  code_t            cur_code_q;
  logic [CntW-1:0]  cnt_q;

  logic [NUM_REGIONS-1:0] active, safe_hit, code_hit, is_entry;
  logic [NUM_REGIONS-1:0] entry_v, data_v;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    smart_region_check #(
      .AddrW(ADDR_W)
    ) u_check (
      .clk_i      (mclk),
      .rst_ni     (reset_n),
      .wr_en_i    (cfg_we && (state_q == StConfig) && (cfg_idx == IDX_W'(g))),
      .wr_sel_i   (cfg_sel),
      .wr_data_i  (cfg_data),
      .mem_addr_i (mem_addr),
      .ins_addr_i (ins_addr),
      .active_o   (active[g]),
      .safe_hit_o (safe_hit[g]),
      .code_hit_o (code_hit[g]),
      .is_entry_o (is_entry[g])
    );
  end

  code_t            fetch_code, ctx_code;
  logic             viol_hit;
  logic [IDX_W-1:0] viol_idx;
  viol_cause_e      viol_cause_d;

  always_comb begin
    // Lowest-numbered active region wins when code ranges overlap.
    fetch_code = CodeNone;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (active[i] && code_hit[i]) fetch_code = code_t'(i);
    end
    ctx_code = ins_valid ? fetch_code : cur_code_q;

    for (int i = 0; i < NUM_REGIONS; i++) begin
      entry_v[i] = ins_valid && (fetch_code == code_t'(i)) && (cur_code_q != code_t'(i)) &&
                   !is_entry[i];
      data_v[i]  = mem_en && active[i] && safe_hit[i] && (ctx_code != code_t'(i));
    end

    viol_hit     = 1'b0;
    viol_idx     = '0;
    viol_cause_d = CauseNone;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (entry_v[i] || data_v[i]) begin
        viol_hit     = 1'b1;
        viol_idx     = IDX_W'(i);
        viol_cause_d = entry_v[i] ? CauseEntry : CauseData;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q       <= StConfig;
      locked_q      <= 1'b0;
      viol_rst_q    <= 1'b0;
      viol_region_q <= '0;
      viol_cause_q  <= CauseNone;
      cur_code_q    <= CodeNone;
      in_safe_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        StConfig: begin
          if (cfg_lock) begin
            state_q  <= StMonitor;
            locked_q <= 1'b1;
          end
        end
        StMonitor: begin
          if (viol_hit) begin
            state_q       <= StResetting;
            viol_rst_q    <= 1'b1;
            viol_region_q <= viol_idx;
            viol_cause_q  <= viol_cause_d;
            cur_code_q    <= CodeNone;
            in_safe_q     <= 1'b0;
            cnt_q         <= '0;
          end else if (ins_valid) begin
            // in_safe tracks the next cur_code so it appears one cycle after the fetch.
            cur_code_q <= fetch_code;
            in_safe_q  <= (fetch_code != CodeNone);
          end
        end
        StResetting: begin
          if (cnt_q == CntW'(RST_CYCLES - 1)) begin
            state_q    <= StMonitor;
            viol_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StConfig;
      endcase
    end
  end

  assign locked        = locked_q;
  assign violation_rst = viol_rst_q;
  assign viol_region   = viol_region_q;
  assign viol_cause    = viol_cause_q;
  assign in_safe_area  = in_safe_q;
  assign dbg_en        = dbg_en_req & ~in_safe_q & ~viol_rst_q;

endmodule

// File: tb/tb_smart_mac_multi.sv
module tb_smart_mac_multi;

  localparam int N  = 2;
  localparam int RC = 4;

  logic        mclk = 1'b0;
  logic        reset_n, cfg_we, cfg_idx, cfg_lock, mem_en, ins_valid, dbg_en_req;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data, mem_addr, ins_addr;
  logic        locked, violation_rst, viol_region, in_safe_area, dbg_en;
  logic [1:0]  viol_cause;

  always #5 mclk = ~mclk;

  smart_mac_multi #(
    .NUM_REGIONS(N),
    .ADDR_W     (16),
    .RST_CYCLES (RC)
  ) dut (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .cfg_lock     (cfg_lock),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .ins_valid    (ins_valid),
    .ins_addr     (ins_addr),
    .dbg_en_req   (dbg_en_req),
    .locked       (locked),
    .violation_rst(violation_rst),
    .viol_region  (viol_region),
    .viol_cause   (viol_cause),
    .in_safe_area (in_safe_area),
    .dbg_en       (dbg_en)
  );

  typedef struct packed {
    logic       vr;
    logic       lk;
    logic       vreg;
    logic [1:0] vc;
    logic       sa;
    logic       dbg;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  // Reference model: plain integers, -1 means "outside every code region".
  int unsigned m_sl[N], m_sh[N], m_cl[N], m_ch[N];
  bit m_locked;
  int m_pulse, m_cur, m_vreg, m_vcause;

  function automatic bit m_active(int i);
    return (m_sl[i] < m_sh[i]) && (m_cl[i] < m_ch[i]);
  endfunction

  task automatic model(input bit rst, we, input int idx, sel, input int unsigned data,
                       input bit lk, men, input int unsigned maddr, input bit iv,
                       input int unsigned iaddr);
    int  fetch, ctx;
    bit  found;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_sl[i] = 0; m_sh[i] = 0; m_cl[i] = 0; m_ch[i] = 0;
      end
      m_locked = 0; m_pulse = 0; m_cur = -1; m_vreg = 0; m_vcause = 0;
    end else if (!m_locked) begin
      if (we && idx < N) begin
        case (sel)
          0: m_sl[idx] = data;
          1: m_sh[idx] = data;
          2: m_cl[idx] = data;
          default: m_ch[idx] = data;
        endcase
      end
      if (lk) m_locked = 1;
    end else if (m_pulse > 0) begin
      m_pulse--;
      m_cur = -1;
    end else begin
      fetch = -1;
      for (int i = N - 1; i >= 0; i--)
        if (m_active(i) && iaddr >= m_cl[i] && iaddr < m_ch[i]) fetch = i;
      ctx   = iv ? fetch : m_cur;
      found = 0;
      for (int i = 0; i < N && !found; i++) begin
        if (iv && fetch == i && m_cur != i && iaddr != m_cl[i]) begin
          found = 1; m_vreg = i; m_vcause = 2;
        end else if (men && m_active(i) && maddr >= m_sl[i] && maddr < m_sh[i] && ctx != i) begin
          found = 1; m_vreg = i; m_vcause = 1;
        end
      end
      if (found) begin
        m_pulse = RC;
        m_cur   = -1;
      end else if (iv) begin
        m_cur = fetch;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input bit rst, we, input int idx, sel, input int unsigned data,
                      input bit lk, men, input int unsigned maddr, input bit iv,
                      input int unsigned iaddr, input bit dreq);
    exp_t e;
    reset_n    = rst;
    cfg_we     = we;
    cfg_idx    = 1'(idx);
    cfg_sel    = 2'(sel);
    cfg_data   = 16'(data);
    cfg_lock   = lk;
    mem_en     = men;
    mem_addr   = 16'(maddr);
    ins_valid  = iv;
    ins_addr   = 16'(iaddr);
    dbg_en_req = dreq;
    model(rst, we, idx, sel, data & 'hFFFF, lk, men, maddr & 'hFFFF, iv, iaddr & 'hFFFF);
    e.vr   = (m_pulse > 0);
    e.lk   = m_locked;
    e.vreg = 1'(m_vreg);
    e.vc   = 2'(m_vcause);
    e.sa   = (m_cur != -1);
    e.dbg  = dreq && !e.sa && !e.vr;
    exp_q.push_back(e);
    @(negedge mclk);
  endtask

  task automatic cyc(input bit men, input int unsigned maddr, input bit iv,
                     input int unsigned iaddr, input bit dreq);
    step(1, 0, 0, 0, 0, 0, men, maddr, iv, iaddr, dreq);
  endtask

  task automatic idle(input int n, input bit dreq);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, dreq);
  endtask

  task automatic cfg(input int idx, sel, input int unsigned data);
    step(1, 1, idx, sel, data, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int unsigned pick_addr(bit code);
    int unsigned r, a;
    r = $urandom_range(0, N - 1);
    case ($urandom_range(0, 4))
      0: a = code ? m_cl[r] : m_sl[r];
      1: a = (code ? m_cl[r] : m_sl[r]) + $urandom_range(0, 12);
      2: a = code ? m_ch[r] : m_sh[r];
      3: a = (code ? m_ch[r] : m_sh[r]) - 1;
      default: a = $urandom_range(0, 'hFFFF);
    endcase
    return a & 'hFFFF;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares every cycle's registered outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge mclk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("violation_rst", 32'(violation_rst), 32'(e.vr));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("viol_region", 32'(viol_region), 32'(e.vreg));
        chk("viol_cause", 32'(viol_cause), 32'(e.vc));
        chk("in_safe_area", 32'(in_safe_area), 32'(e.sa));
        chk("dbg_en", 32'(dbg_en), 32'(e.dbg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    bit men, iv, we, lk, dreq, rst;
    do_reset();
    do_reset();
    // Program two regions, lock, then try to rewrite a locked field.
    cfg(0, 0, 'h0100); cfg(0, 1, 'h0110); cfg(0, 2, 'h8000); cfg(0, 3, 'h8100);
    cfg(1, 0, 'h0200); cfg(1, 1, 'h0210); cfg(1, 2, 'h9000); cfg(1, 3, 'h9100);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cfg(0, 0, 'h0000);
    cyc(1, 'h00F0, 0, 0, 0);
    idle(2, 0);
    // Legal entry and data use from region 0, debug requested throughout.
    cyc(0, 0, 1, 'h8000, 1);
    cyc(0, 0, 1, 'h8002, 1);
    cyc(1, 'h0104, 0, 0, 1);
    idle(2, 1);
    // Data violation from outside any code region; second access during pulse.
    cyc(0, 0, 1, 'h4000, 0);
    cyc(1, 'h0104, 0, 0, 1);
    cyc(1, 'h0204, 0, 0, 1);
    idle(5, 1);
    // Entry violation, then a legal entry at the entry point.
    cyc(0, 0, 1, 'h4000, 0);
    cyc(0, 0, 1, 'h9010, 0);
    idle(5, 0);
    cyc(0, 0, 1, 'h4000, 0);
    cyc(0, 0, 1, 'h9000, 0);
    cyc(0, 0, 1, 'h9004, 0);
    cyc(1, 'h0204, 0, 0, 0);
    // Cross-region data access.
    cyc(0, 0, 1, 'h4000, 0);
    cyc(0, 0, 1, 'h8000, 0);
    cyc(1, 'h0204, 0, 0, 0);
    idle(5, 0);
    // Simultaneous entry (region 0) and data (region 1) violations.
    cyc(0, 0, 1, 'h4000, 0);
    cyc(1, 'h0204, 1, 'h8010, 1);
    idle(2, 1);
    do_reset();
    idle(2, 1);

    // Randomised rounds: random tables (some empty), traffic before and after lock.
    for (int round = 0; round < 10; round++) begin
      do_reset();
      for (int r = 0; r < N; r++) begin
        int unsigned lo, clo;
        lo  = $urandom_range(0, 'h3000);
        clo = $urandom_range('h8000, 'hC000);
        cfg(r, 0, lo);
        cfg(r, 1, lo + $urandom_range(0, 'h40));
        cfg(r, 2, clo);
        cfg(r, 3, clo + $urandom_range(0, 'h100));
      end
      for (int k = 0; k < 15; k++)
        cyc($urandom_range(0, 1), pick_addr(0), $urandom_range(0, 1), pick_addr(1),
            $urandom_range(0, 1));
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 'hFFFF), 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 180; k++) begin
        rst  = ($urandom_range(0, 199) != 0);
        we   = ($urandom_range(0, 9) == 0);
        lk   = ($urandom_range(0, 19) == 0);
        men  = ($urandom_range(0, 9) < 4);
        iv   = ($urandom_range(0, 1) == 1);
        dreq = ($urandom_range(0, 1) == 1);
        step(rst, we, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 'hFFFF),
             lk, men, pick_addr(0), iv, pick_addr(1), dreq);
      end
    end

    done = 1'b1;
    @(posedge mclk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/smart_mac_multi.md
Name: smart_mac_multi

Overview:
- Parametrised successor to the single-region SMART memory access controller.
- Guards NUM_REGIONS independent key regions. Each key region has its own trusted code region, programmed at boot through a write-once configuration table.
- Per region it enforces two rules and forces a timed CPU reset on a breach:
  - Data rule: only code in the matching trusted region may touch the key region.
  - Entry rule: control may enter the trusted code region only at its entry point (its first address).
- Sits between the CPU memory/fetch buses and the system reset/debug logic.

Parameters:
- NUM_REGIONS, 4, number of key/code region pairs (1..8).
- ADDR_W, 16, address width of the data and instruction buses.
- RST_CYCLES, 4, length in mclk cycles of the violation reset pulse (>=1).
- IDX_W, $clog2(NUM_REGIONS) (min 1), region index width; derived, not overridable.

Ports:
- mclk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  IDX_W  region index to write.
- cfg_sel  in  2  field select: 0 safe_lo, 1 safe_hi, 2 code_lo, 3 code_hi.
- cfg_data  in  ADDR_W  field value.
- cfg_lock  in  1  freezes the table and starts monitoring.
- mem_en  in  1  data access valid this cycle.
- mem_addr  in  ADDR_W  data access address.
- ins_valid  in  1  instruction fetch valid this cycle.
- ins_addr  in  ADDR_W  fetch address.
- dbg_en_req  in  1  debug unit requests enable.
- locked  out  1  table frozen.
- violation_rst  out  1  active-high reset request to the CPU.
- viol_region  out  IDX_W  region index of the last violation.
- viol_cause  out  2  cause of the last violation: 00 none, 01 data, 10 entry.
- in_safe_area  out  1  CPU is currently executing inside some trusted code region.
- dbg_en  out  1  gated debug enable.

Behaviour:
- Reset (reset_n=0 at an mclk edge):
  - All region fields = 0; state = CONFIG.
  - locked=0, violation_rst=0, viol_region=0, viol_cause=00, in_safe_area=0.
  - cur_code = NONE.
- Reset overrides everything, including a pulse already in progress.
- Region ranges:
  - Ranges are inclusive-low, exclusive-high.
  - A region is active only when safe_lo<safe_hi and code_lo<code_hi. Inactive regions never match.
  - All comparisons are unsigned, ADDR_W bits, with no wrap-around.
- State machine:
  - CONFIG:
    - cfg_we writes the selected field next cycle.
    - cfg_lock moves to MONITOR and sets locked=1.
    - cfg_we and cfg_lock in the same cycle: the write lands, then lock takes effect.
    - No checks run in CONFIG.
  - MONITOR: per-cycle checks, described below.
  - RESETTING:
    - violation_rst=1 for exactly RST_CYCLES cycles (internal counter), then return to MONITOR.
    - All new violations are ignored.
    - cur_code is held at NONE.
  - Once locked, cfg_we and cfg_lock are ignored until reset_n.
- Fetch context:
  - fetch_code = index of the lowest-numbered active region whose code range contains ins_addr, else NONE.
  - The fetch context this cycle is fetch_code when ins_valid=1, otherwise cur_code.
  - cur_code updates to fetch_code on each ins_valid in MONITOR.
- Entry violation (region i):
  - Condition: ins_valid, fetch_code=i, cur_code!=i, and ins_addr!=code_lo[i].
  - Sequential fetches inside the region are legal.
  - Leaving the region is always legal.
- Data violation (region i):
  - Condition: mem_en, mem_addr inside safe range i, and the fetch context is not i.
- Priority when several violations occur in one cycle:
  - Lowest region index wins.
  - Within a region, entry beats data.
- On a violation detected in cycle N:
  - In cycle N+1: state=RESETTING, violation_rst=1, viol_region and viol_cause latched.
  - viol_region and viol_cause hold until the next violation or reset_n. They survive the reset pulse.
- in_safe_area is registered: 1 when cur_code!=NONE. Latency is 1 cycle after the fetch.
- dbg_en = dbg_en_req & ~in_safe_area & ~violation_rst. This is combinational.
- Unlocked device: never raises violation_rst; dbg_en follows dbg_en_req.

Decomposition:
- Package smart_mac_pkg holds:
  - cfg_sel encodings;
  - viol_cause encodings;
  - state encoding (CONFIG, MONITOR, RESETTING);
  - NONE sentinel for cur_code.
- Sub-module smart_region_check: one instance per region. It holds the four registered bounds and outputs:
  - active;
  - safe_hit(mem_addr);
  - code_hit(ins_addr);
  - is_entry(ins_addr).
- The top level holds the priority encoder, the FSM, the pulse counter, cur_code and the output registers.

Test Plan:
- Config and lock (NUM_REGIONS=2, RST_CYCLES=4):
  - Region 0: safe 0x0100-0x0110, code 0x8000-0x8100.
  - Region 1: safe 0x0200-0x0210, code 0x9000-0x9100.
  - Lock -> locked=1 next cycle.
  - Further cfg_we to region 0 safe_lo=0x0000 is ignored: a read at 0x00F0 never faults.
- Legal path: fetch 0x8000, fetch 0x8002, mem_en @0x0104 -> no violation; in_safe_area=1 one cycle after 0x8000; dbg_en=0 while dbg_en_req=1.
- Data violation: cur_code=NONE, mem_en @0x0104 -> next cycle violation_rst=1 for exactly 4 cycles, viol_region=0, viol_cause=01. A mem_en @0x0204 during the pulse is ignored.
- Entry violation: from 0x4000, fetch 0x9010 -> viol_region=1, viol_cause=10. Fetch 0x9000 instead -> no violation.
- Cross-region: in code 0 (fetch 0x8000), mem_en @0x0204 -> data violation on region 1.
- Simultaneous violations: fetch 0x8010 from NONE plus mem_en @0x0204 in the same cycle -> region 0 entry reported.
- reset_n=0 mid-pulse -> violation_rst=0, locked=0, viol_cause=00 next cycle.
